// File: rtl/dfi_phy_hs_pkg.sv
// Shared types, state encodings and default timing constants for the DFI PHY-side
// handshake responder.
package dfi_phy_hs_pkg;

  localparam int unsigned LP_ACK_DLY_DEF      = 3;
  localparam int unsigned TLP_RESP_DEF        = 8;
  localparam int unsigned CTRLUPD_ACK_DLY_DEF = 2;
  localparam int unsigned PHYUPD_HOLD_DEF     = 4;
  localparam int unsigned TPHYUPD_RESP_DEF    = 16;

  typedef logic [1:0] phyupd_type_t;
  typedef logic [5:0] lp_wakeup_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_ACK
  } lp_state_e;

  typedef enum logic [2:0] {
    U_IDLE,
    U_CTRL_WAIT,
    U_CTRL_ACK,
    U_PHY_REQ,
    U_PHY_HOLD,
    U_PHY_DROP
  } upd_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dfi_phy_hs_responder_if.sv
// DFI handshake signal bundle between the controller/calibration side (master)
// and the PHY-side responder (slave).
interface dfi_phy_hs_responder_if;
  import dfi_phy_hs_pkg::*;

  logic         lp_ctrl_req;
  lp_wakeup_t   lp_ctrl_wakeup;
  logic         lp_ctrl_ack;
  logic         lp_data_req;
  lp_wakeup_t   lp_data_wakeup;
  logic         lp_data_ack;
  logic         lp_accept;
  lp_wakeup_t   lp_ctrl_wakeup_q;
  lp_wakeup_t   lp_data_wakeup_q;
  logic         ctrlupd_req;
  logic         ctrlupd_ack;
  logic         phyupd_req;
  phyupd_type_t phyupd_type;
  logic         phyupd_ack;
  logic         init_start;
  logic         upd_trigger;
  phyupd_type_t upd_trigger_type;
  logic         upd_busy;
  logic         upd_done;
  logic         upd_timeout;

  modport slave (
    input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, lp_accept,
           ctrlupd_req, phyupd_ack, init_start, upd_trigger, upd_trigger_type,
    output lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q,
           ctrlupd_ack, phyupd_req, phyupd_type, upd_busy, upd_done, upd_timeout
  );

  modport master (
    output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, lp_accept,
           ctrlupd_req, phyupd_ack, init_start, upd_trigger, upd_trigger_type,
    input  lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q,
           ctrlupd_ack, phyupd_req, phyupd_type, upd_busy, upd_done, upd_timeout
  );

endinterface

// File: rtl/dfi_lp_resp.sv
// One DFI low-power handshake channel: accepts a request, acks it after a fixed
// delay and latches the wakeup code presented at acceptance.
module dfi_lp_resp
  import dfi_phy_hs_pkg::*;
#(
  parameter int unsigned LP_ACK_DLY = LP_ACK_DLY_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  lp_wakeup_t i_wakeup,
  input  logic       i_accept,
  input  logic       i_block,
  output logic       o_ack,
  output lp_wakeup_t o_wakeup_q
);

  localparam int unsigned CW = cnt_width(LP_ACK_DLY);
  localparam logic [CW-1:0] CNT_LAST = CW'(LP_ACK_DLY - 1);

  lp_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic        r_ack;
  lp_wakeup_t  r_wakeup;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= L_IDLE;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_wakeup <= '0;
    end else begin
      case (r_state)
        L_IDLE: begin
          if (i_req && i_accept && !i_block) begin
            r_state  <= L_WAIT;
            r_cnt    <= '0;
            r_wakeup <= i_wakeup;
          end
        end
        L_WAIT: begin
          // A request dropped before the ack is an abandon: no ack is ever given.
          if (!i_req) begin
            r_state <= L_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= L_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        L_ACK: begin
          if (!i_req) begin
            r_state <= L_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= L_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_wakeup_q = r_wakeup;

endmodule

// File: rtl/dfi_phy_hs_responder.sv
// PHY-side DFI handshake endpoint: LP ctrl/data acks, ctrlupd ack and PHY-initiated
// phyupd requests. Define DFI_LP_UPD_EXCL_EN to make LP entry and updates mutually exclusive.
module dfi_phy_hs_responder
  import dfi_phy_hs_pkg::*;
#(
  parameter int unsigned LP_ACK_DLY      = LP_ACK_DLY_DEF,
  parameter int unsigned TLP_RESP        = TLP_RESP_DEF,
  parameter int unsigned CTRLUPD_ACK_DLY = CTRLUPD_ACK_DLY_DEF,
  parameter int unsigned PHYUPD_HOLD     = PHYUPD_HOLD_DEF,
  parameter int unsigned TPHYUPD_RESP    = TPHYUPD_RESP_DEF
) (
  input logic                   clock,
  input logic                   reset,
  dfi_phy_hs_responder_if.slave bus
);

  if (LP_ACK_DLY == 0 || LP_ACK_DLY >= TLP_RESP || CTRLUPD_ACK_DLY == 0 ||
      PHYUPD_HOLD == 0 || TPHYUPD_RESP == 0) begin : g_bad_params
    $error("dfi_phy_hs_responder: illegal timing parameters");
  end

  localparam int unsigned CCW = cnt_width(CTRLUPD_ACK_DLY);
  localparam int unsigned HCW = cnt_width(PHYUPD_HOLD);
  localparam int unsigned TCW = cnt_width(TPHYUPD_RESP);
  localparam logic [CCW-1:0] C_LAST = CCW'(CTRLUPD_ACK_DLY - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(PHYUPD_HOLD - 1);
  localparam logic [TCW-1:0] T_MAX  = TCW'(TPHYUPD_RESP);
  localparam logic [TCW-1:0] T_LAST = TCW'(TPHYUPD_RESP - 1);

  logic       w_lp_ctrl_ack;
  logic       w_lp_data_ack;
  lp_wakeup_t w_lp_ctrl_wakeup_q;
  lp_wakeup_t w_lp_data_wakeup_q;
  logic       w_lp_block;
  logic       w_phy_start_ok;

  upd_state_e   r_state;
  logic         r_pend;
  phyupd_type_t r_pend_type;
  logic [CCW-1:0] r_ccnt;
  logic [HCW-1:0] r_hcnt;
  logic [TCW-1:0] r_tcnt;
  logic         r_ctrlupd_ack;
  logic         r_phyupd_req;
  phyupd_type_t r_phyupd_type;
  logic         r_done;
  logic         r_timeout;

`ifdef DFI_LP_UPD_EXCL_EN
  assign w_lp_block     = (r_state != U_IDLE);
  assign w_phy_start_ok = !(w_lp_ctrl_ack || w_lp_data_ack);
`else
  assign w_lp_block     = 1'b0;
  assign w_phy_start_ok = 1'b1;
`endif

  dfi_lp_resp #(.LP_ACK_DLY(LP_ACK_DLY)) u_lp_ctrl (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_req      (bus.lp_ctrl_req),
    .i_wakeup   (bus.lp_ctrl_wakeup),
    .i_accept   (bus.lp_accept),
    .i_block    (w_lp_block),
    .o_ack      (w_lp_ctrl_ack),
    .o_wakeup_q (w_lp_ctrl_wakeup_q)
  );

  dfi_lp_resp #(.LP_ACK_DLY(LP_ACK_DLY)) u_lp_data (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_req      (bus.lp_data_req),
    .i_wakeup   (bus.lp_data_wakeup),
    .i_accept   (bus.lp_accept),
    .i_block    (w_lp_block),
    .o_ack      (w_lp_data_ack),
    .o_wakeup_q (w_lp_data_wakeup_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= U_IDLE;
      r_pend        <= 1'b0;
      r_pend_type   <= '0;
      r_ccnt        <= '0;
      r_hcnt        <= '0;
      r_tcnt        <= '0;
      r_ctrlupd_ack <= 1'b0;
      r_phyupd_req  <= 1'b0;
      r_phyupd_type <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (bus.upd_trigger) begin
        r_pend      <= 1'b1;
        r_pend_type <= bus.upd_trigger_type;
      end
      case (r_state)
        U_IDLE: begin
          // A trigger landing on the launch edge is a new request and stays pending.
          if (!bus.init_start) begin
            if (bus.ctrlupd_req) begin
              r_state <= U_CTRL_WAIT;
              r_ccnt  <= '0;
            end else if (r_pend && !bus.phyupd_ack && w_phy_start_ok) begin
              r_state       <= U_PHY_REQ;
              r_phyupd_req  <= 1'b1;
              r_phyupd_type <= r_pend_type;
              r_tcnt        <= '0;
              if (!bus.upd_trigger) r_pend <= 1'b0;
            end
          end
        end
        U_CTRL_WAIT: begin
          if (!bus.ctrlupd_req) begin
            r_state <= U_IDLE;
          end else if (r_ccnt == C_LAST) begin
            r_state       <= U_CTRL_ACK;
            r_ctrlupd_ack <= 1'b1;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        U_CTRL_ACK: begin
          if (!bus.ctrlupd_req) begin
            r_state       <= U_IDLE;
            r_ctrlupd_ack <= 1'b0;
          end
        end
        U_PHY_REQ: begin
          if (bus.phyupd_ack) begin
            r_state <= U_PHY_HOLD;
            r_hcnt  <= '0;
          end else if (r_tcnt != T_MAX) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == T_LAST) r_timeout <= 1'b1;
          end
        end
        U_PHY_HOLD: begin
          if (r_hcnt == H_LAST) begin
            r_state       <= U_PHY_DROP;
            r_phyupd_req  <= 1'b0;
            r_phyupd_type <= '0;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        U_PHY_DROP: begin
          if (!bus.phyupd_ack) begin
            r_state <= U_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state       <= U_IDLE;
          r_ctrlupd_ack <= 1'b0;
          r_phyupd_req  <= 1'b0;
          r_phyupd_type <= '0;
        end
      endcase
    end
  end

  assign bus.lp_ctrl_ack      = w_lp_ctrl_ack;
  assign bus.lp_data_ack      = w_lp_data_ack;
  assign bus.lp_ctrl_wakeup_q = w_lp_ctrl_wakeup_q;
  assign bus.lp_data_wakeup_q = w_lp_data_wakeup_q;
  assign bus.ctrlupd_ack      = r_ctrlupd_ack;
  assign bus.phyupd_req       = r_phyupd_req;
  assign bus.phyupd_type      = r_phyupd_type;
  assign bus.upd_busy         = (r_state != U_IDLE);
  assign bus.upd_done         = r_done;
  assign bus.upd_timeout      = r_timeout;

endmodule

// File: doc/dfi_phy_hs_responder.md
Name: dfi_phy_hs_responder

Overview:
PHY-side endpoint of the DFI control handshakes. It acknowledges controller-initiated low-power requests (lp_ctrl, lp_data) and controller update requests (ctrlupd). It also initiates PHY update requests (phyupd_req) on behalf of internal PHY calibration logic. It sits between the DFI port and the PHY's calibration/power sequencer, and is the counterpart to the DFI controller-side driver and monitor.

Parameters:
LP_ACK_DLY, 3, cycles from sampled lp_*_req high to lp_*_ack high; must be < TLP_RESP
TLP_RESP, 8, controller abandon window; used for legality check only
CTRLUPD_ACK_DLY, 2, cycles from ctrlupd_req high to ctrlupd_ack high
PHYUPD_HOLD, 4, cycles phyupd_req is held after phyupd_ack seen
TPHYUPD_RESP, 16, cycles without phyupd_ack before upd_timeout pulses

Ports:
clock  in  1  DFI clock, all logic on posedge
reset  in  1  synchronous, active-high
lp_ctrl_req  in  1  controller LP control request
lp_ctrl_wakeup  in  6  wakeup code, latched on accept
lp_ctrl_ack  out  1  LP control acknowledge
lp_data_req  in  1  controller LP data request
lp_data_wakeup  in  6  wakeup code, latched on accept
lp_data_ack  out  1  LP data acknowledge
lp_accept  in  1  PHY permits LP entry; 0 = decline (never ack)
lp_ctrl_wakeup_q  out  6  latched lp_ctrl_wakeup
lp_data_wakeup_q  out  6  latched lp_data_wakeup
ctrlupd_req  in  1  controller update request
ctrlupd_ack  out  1  controller update acknowledge
phyupd_req  out  1  PHY update request
phyupd_type  out  2  PHY update type
phyupd_ack  in  1  controller PHY update acknowledge
init_start  in  1  DFI init in progress; blocks all update activity
upd_trigger  in  1  one-cycle pulse from calibration: request a phyupd
upd_trigger_type  in  2  type for upd_trigger
upd_busy  out  1  update FSM not in U_IDLE
upd_done  out  1  one-cycle pulse: phyupd handshake complete
upd_timeout  out  1  one-cycle pulse: TPHYUPD_RESP elapsed without ack

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs and state are 0 / IDLE one edge after reset is sampled high, including mid-handshake. The pending trigger is cleared.
- LP FSM (one per channel), states L_IDLE, L_WAIT, L_ACK:
  - L_IDLE: req & lp_accept -> L_WAIT, counter = 0, wakeup latched.
  - L_WAIT: req low -> L_IDLE with no ack (controller abandoned). Counter == LP_ACK_DLY-1 -> L_ACK; ack is driven high from the next cycle.
  - L_ACK: ack = 1 while req stays high. When req is sampled low, ack goes low on the next edge -> L_IDLE.
  - A new req is accepted no earlier than one cycle after ack is low.
- Update FSM, states U_IDLE, U_CTRL_WAIT, U_CTRL_ACK, U_PHY_REQ, U_PHY_HOLD, U_PHY_DROP:
  - pend_q is set by upd_trigger (type latched into pend_type_q) and cleared on entry to U_PHY_REQ. A trigger while pend_q is already set overwrites the type.
  - U_IDLE, init_start = 1: stay idle.
  - U_IDLE, ctrlupd_req = 1: -> U_CTRL_WAIT. ctrlupd_req wins over pend_q when both are present in the same cycle.
  - U_IDLE, pend_q = 1 and ctrlupd_req = 0: -> U_PHY_REQ. phyupd_req = 1 and phyupd_type = pend_type_q from the next cycle.
  - U_CTRL_WAIT: req low -> U_IDLE. After CTRLUPD_ACK_DLY cycles -> U_CTRL_ACK.
  - U_CTRL_ACK: ctrlupd_ack = 1 while req is high. ctrlupd_ack is never high while ctrlupd_req is low, except the single cycle after req falls. Req low -> ack 0 -> U_IDLE.
  - U_PHY_REQ: phyupd_ack high -> U_PHY_HOLD.
    - The timeout counter saturates. At TPHYUPD_RESP, upd_timeout pulses exactly once.
    - phyupd_req stays high after timeout; the ack is still awaited.
  - U_PHY_HOLD: after PHYUPD_HOLD cycles, drop phyupd_req -> U_PHY_DROP.
  - U_PHY_DROP: wait for phyupd_ack low, then upd_done pulses -> U_IDLE.
  - phyupd_req is never re-raised while phyupd_ack is high.
- phyupd_type is held stable for the whole time phyupd_req is high. phyupd_type is 0 when idle.
- ctrlupd_ack and phyupd_req are never high simultaneously.
- All counters are sized by $clog2 of their parameter + 1. Counters saturate and never wrap.

Optional Feature:
- Macro: DFI_LP_UPD_EXCL_EN.
- With the macro defined:
  - An LP request arriving while upd_busy = 1 stays in L_IDLE until update returns to U_IDLE. It is acked only if req is still high at that point.
  - U_IDLE does not start a phyupd while either lp_*_ack is high; pend_q is retained.
- Without the macro: the LP and update FSMs are fully independent.

Decomposition:
- Package dfi_phy_hs_pkg holds:
  - typedef enums lp_state_e and upd_state_e;
  - typedef logic [1:0] phyupd_type_t and logic [5:0] lp_wakeup_t;
  - default parameter constants.
- Sub-module dfi_lp_resp holds the LP FSM plus wakeup latch. It is instantiated twice, for ctrl and data.

Test Plan:
- lp_ctrl_req high at cycle 10, lp_accept=1, wakeup=6'h0A -> lp_ctrl_ack high at cycle 13, lp_ctrl_wakeup_q=6'h0A. Req low at cycle 20 -> ack low at cycle 21.
- lp_data_req high for 2 cycles only -> lp_data_ack never asserts, FSM returns to L_IDLE. Same request with lp_accept=0 -> no ack.
- ctrlupd_req and upd_trigger (type 2'b01) in the same cycle -> ctrlupd_ack after 2 cycles. phyupd_req=1 with phyupd_type=01 only after ctrlupd_ack has fallen.
- upd_trigger, phyupd_ack returned 5 cycles after req -> req held 4 more cycles, dropped. Ack dropped 2 cycles later -> upd_done single pulse.
- upd_trigger with phyupd_ack withheld 30 cycles -> upd_timeout pulses once at cycle 16 of req, req stays high. A late ack completes normally.
- reset asserted while in U_PHY_HOLD -> phyupd_req, upd_busy, and all acks are 0 next edge. A re-applied trigger starts a fresh handshake.
